// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM encoding,
// byte-mask patterns and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    end
    return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction

  // Size is carried in funct3[1:0]; only H and W can straddle a word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: access mask, store data shift and
// load data shift with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata_pair,
  output logic [7:0]  mask,
  output logic [63:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [3:0]  base_mask;
  logic [63:0] rd_sh;
  logic [4:0]  sh_bits;
  logic        unused_rd_hi;

  assign sh_bits      = {offset, 3'b000};
  assign unused_rd_hi = ^rd_sh[63:32];

  always_comb begin
    case (funct3[1:0])
      SZ_B:    base_mask = MASK_B;
      SZ_H:    base_mask = MASK_H;
      default: base_mask = MASK_W;
    endcase
  end

  // Bits [7:4] of the mask are the lanes that spill into the next word.
  assign mask     = {4'b0000, base_mask} << offset;
  assign wdata_sh = {32'h0000_0000, wdata} << sh_bits;
  assign rd_sh    = rdata_pair >> sh_bits;

  always_comb begin
    case (funct3[1:0])
      SZ_B:    rdata_ext = funct3[2] ? {24'h00_0000, rd_sh[7:0]}
                                     : {{24{rd_sh[7]}}, rd_sh[7:0]};
      SZ_H:    rdata_ext = funct3[2] ? {16'h0000, rd_sh[15:0]}
                                     : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: rdata_ext = rd_sh[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, one or two RAM beats.
// LSU_MISALIGN_SPLIT_EN enables split misaligned H/W; otherwise they are rejected.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_sel,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       beat0_q, beat0_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]       beat1_q, beat1_d;
  logic [ADDR_W-3:0] word_nxt;
`endif

  logic              accept;
  logic              reject;
  logic [ADDR_W-3:0] word_idx;
  logic [63:0]       rdata_pair;
  logic [7:0]        mask;
  logic [63:0]       wdata_sh;
  logic [31:0]       rdata_ext;
  logic              unused_bits;

  assign accept   = req_valid && (state_q == ST_IDLE);
  assign word_idx = addr_q[ADDR_W-1:2];

`ifdef LSU_MISALIGN_SPLIT_EN
  assign reject     = f3_illegal(req_we, req_funct3);
  assign rdata_pair = {beat1_q, beat0_q};
  assign word_nxt   = word_idx + {{(ADDR_W-3){1'b0}}, 1'b1};
`else
  assign reject     = f3_illegal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
  assign rdata_pair = {32'h0000_0000, beat0_q};
`endif

  assign unused_bits = ^{req_addr[31:ADDR_W], mask[7:4], wdata_sh[63:32]};

  lsu_align u_align (
    .funct3     (f3_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata_pair (rdata_pair),
    .mask       (mask),
    .wdata_sh   (wdata_sh),
    .rdata_ext  (rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    beat0_d = beat0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    beat1_d = beat1_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          err_d   = reject;
          beat0_d = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          beat1_d = '0;
`endif
          state_d = reject ? ST_RESP : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (!we_q) beat0_d = mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        state_d = (mask[7:4] != 4'b0000) ? ST_BEAT1 : ST_RESP;
`else
        state_d = ST_RESP;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_BEAT1: begin
        if (!we_q) beat1_d = mem_rdata;
        state_d = ST_RESP;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      beat0_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      beat1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      beat0_q <= beat0_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      beat1_q <= beat1_d;
`endif
    end
  end

  // Outputs are gated by rst so an in-flight beat or response dies immediately.
  always_comb begin
    req_ready  = (state_q == ST_IDLE) || rst;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_sel    = '0;
    mem_wdata  = '0;
    if (!rst) begin
      case (state_q)
        ST_BEAT0: begin
          mem_we    = we_q;
          mem_addr  = {word_idx, 2'b00};
          mem_sel   = mask[3:0];
          mem_wdata = wdata_sh[31:0];
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_BEAT1: begin
          mem_we    = we_q;
          mem_addr  = {word_nxt, 2'b00};
          mem_sel   = mask[7:4];
          mem_wdata = wdata_sh[63:32];
        end
`endif
        ST_RESP: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
          resp_rdata = (err_q || we_q) ? '0 : rdata_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width of the data-memory port.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid input 1 and req_ready output 1: the pipeline request handshake.
REQ-005 SHALL have port req_we  input  1  store when 1, load when 0.
REQ-006 SHALL have port req_funct3  input  3  RISC-V width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have ports req_addr input 32 (byte address) and req_wdata input 32 (store data, low-aligned).
REQ-008 SHALL have ports resp_valid output 1, resp_rdata output 32 and resp_err output 1: the completion pulse, load result and error flag.
REQ-009 SHALL have ports mem_we output 1, mem_addr output ADDR_W, mem_sel output 4 and mem_wdata output 32 to the data RAM.
REQ-010 SHALL have port mem_rdata  input  32  RAM read data, valid combinationally in the same cycle as mem_addr.

Function
REQ-011 SHALL implement FSM states IDLE, BEAT0, BEAT1 and RESP; req_ready = 1 only in IDLE.
REQ-012 SHALL register the request (we, funct3, addr, wdata) on req_valid&&req_ready and enter BEAT0; illegal or (per REQ-024) rejected misaligned requests SHALL enter RESP directly.
REQ-013 SHALL treat as illegal: load funct3 011/110/111 and store funct3 other than 000/001/010.
REQ-014 SHALL drive in BEAT0 mem_addr = {addr[ADDR_W-1:2],2'b00} and mem_sel = byte mask (B 0001, H 0011, W 1111) shifted left by addr[1:0], truncated to 4 bits.
REQ-015 SHALL go from BEAT0 to BEAT1 only when the shifted mask overflows bit 3 (H at offset 3, W at offsets 1-3), otherwise to RESP.
REQ-016 SHALL drive in BEAT1 mem_addr = next word (word index + 1, wrapping modulo 2^(ADDR_W-2)) and mem_sel = the overflowed mask bits [7:4]; BEAT1 always goes to RESP.
REQ-017 SHALL form store data as {32'b0,wdata} << 8*addr[1:0]: bits [31:0] on mem_wdata in BEAT0, bits [63:32] in BEAT1; mem_we = req_we in BEAT states only.
REQ-018 SHALL capture mem_rdata at the end of each BEAT state for loads, right-shift {beat1,beat0} by 8*addr[1:0], then sign-extend (B,H) or zero-extend (BU,HU).
REQ-019 SHALL assert resp_valid for exactly one cycle in RESP with no back-pressure; resp_rdata = load result, 0 for stores and errors; resp_err = 1 for illegal or rejected requests.
REQ-020 SHALL hold mem_we=0, mem_sel=0, mem_addr=0 and mem_wdata=0 in IDLE and RESP; errored requests SHALL produce no memory beat.
REQ-021 SHALL give latency: accept cycle N, resp_valid at N+2 for single-beat, N+3 for split accesses and N+1 for errors; the next request SHALL be accepted no earlier than the cycle after RESP.

Reset
REQ-022 SHALL, while rst=1, force state IDLE, req_ready=1 and resp_valid=0, and zero resp_rdata, resp_err, all mem_* outputs and all captured data.
REQ-023 SHALL abandon an access when rst is asserted mid-BEAT or mid-RESP: no further mem_we, and no resp_valid for the abandoned request.

Configuration
REQ-024 SHALL honour macro LSU_MISALIGN_SPLIT_EN: defined -> misaligned H/W are split per REQ-015/016; undefined -> any H with addr[0]=1 or W with addr[1:0]!=0 is rejected with resp_err=1 and no beat, and state BEAT1 and its datapath are not compiled.

Structure
REQ-025 SHALL place funct3 codes, FSM state encoding and byte-mask constants in shared package lsu_pkg.
REQ-026 SHALL use one sub-module, lsu_align: combinational mask generation, store shift, load shift and extension; the FSM and registers stay in lsu_ctrl.

Verification
REQ-027 SHALL check: SW addr 0x010, wdata 0xDEADBEEF -> one beat, mem_addr 0x010, sel 1111, mem_we 1; resp_valid at N+2, resp_err 0.
REQ-028 SHALL check: RAM word 0x004 = 0x0080FF7F; LB at 0x005 -> resp_rdata 0xFFFFFFFF; LBU at 0x005 -> 0x000000FF; LH at 0x004 -> 0xFFFFFF7F.
REQ-029 SHALL check (with LSU_MISALIGN_SPLIT_EN): SW 0x11223344 at 0x003 -> beat0 addr 0x000 sel 1000 data 0x44000000, beat1 addr 0x004 sel 0111 data 0x00112233; LW 0x003 reads back 0x11223344 at N+3.
REQ-030 SHALL check wrap: LH at 0xFFF (split) -> beat1 mem_addr 0x000, sel 0001.
REQ-031 SHALL check: funct3 011 load -> resp_err 1 at N+1, mem_sel never nonzero; and without the macro, LW at 0x002 -> resp_err 1, no beat.
REQ-032 SHALL check: rst asserted during BEAT0 of a store -> mem_we 0 the next cycle, no resp_valid, req_ready 1 after reset.
